// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over back-to-back
// windows of GATE_CYCLES clocks and reports each completed window with a valid strobe.
module freq_meter #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow,
    output logic             no_signal,
    output logic             busy,
    output logic             dbg_state
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if (GATE_CYCLES < 2 || CLK_FREQ < 1) begin : g_bad_params
            $error("freq_meter: GATE_CYCLES must be at least 2 and CLK_FREQ positive");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_GATE} state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_overflow;
    logic             r_no_signal;
    logic             r_busy;

    logic             w_edge;
    logic             w_last;
    logic             w_sat;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_next_ovf;

    // s1 absorbs metastability; the edge is taken from the settled s2/s3 pair.
    assign w_edge     = r_s2 & ~r_s3;
    assign w_last     = (r_gate_cnt == GATE_LAST);
    assign w_sat      = (r_edge_cnt == CNT_MAX);
    assign w_next_cnt = (w_edge && !w_sat) ? (r_edge_cnt + CNT_ONE) : r_edge_cnt;
    assign w_next_ovf = r_ovf | (w_edge & w_sat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_gate_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_no_signal <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_s1    <= sig_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state    <= S_GATE;
                        r_busy     <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf      <= 1'b0;
                    end
                end
                S_GATE: begin
                    if (w_last) begin
                        // The edge seen in the last gate cycle still belongs to this window.
                        r_count     <= w_next_cnt;
                        r_overflow  <= w_next_ovf;
                        r_no_signal <= (w_next_cnt == '0);
                        r_valid     <= 1'b1;
                        r_gate_cnt  <= '0;
                        r_edge_cnt  <= '0;
                        r_ovf       <= 1'b0;
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf      <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                        r_edge_cnt <= w_next_cnt;
                        r_ovf      <= w_next_ovf;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out = r_count;
    assign valid     = r_valid;
    assign overflow  = r_overflow;
    assign no_signal = r_no_signal;
    assign busy      = r_busy;
    assign dbg_state = (r_state == S_GATE);

endmodule
